// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the EX stage and the mul/div unit.
interface muldiv_seq_if;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] r;

    modport master (
        output start, flush, op, a, b,
        input  busy, done, r
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, done, r
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one radix-2 step per cycle,
// signed ops run on magnitudes with a sign fix-up at the end.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 6;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;

    // Operand sign handling on the latched request
    logic            is_div, a_signed, b_signed, neg_pre, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div   = op_q[2];
    assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                      (op_q == OP_DIV)  || (op_q == OP_REM);
    assign b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    // REM follows the dividend sign only, so b's sign enters only for MULH/DIV
    assign neg_pre  = (a_signed & a_q[XLEN-1]) ^
                      (((op_q == OP_MULH) || (op_q == OP_DIV)) & b_q[XLEN-1]);
    assign a_mag    = (a_signed && a_q[XLEN-1]) ? XLEN'(-a_q) : a_q;
    assign b_mag    = (b_signed && b_q[XLEN-1]) ? XLEN'(-b_q) : b_q;
    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                      (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // One shift-add multiply step and one restoring divide step
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // remainder after the left shift can reach 33 bits when the divisor has its MSB set
    assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_rem - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Result selection with sign fix-up
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, res_fix;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign res_fix  = !is_div ? ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN])
                              : (op_q[1] ? rem_fix : quot_fix);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start && !bus.flush) begin
                    state_d = S_PREP;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end
            end
            S_PREP: begin
                neg_d  = neg_pre;
                cnt_d  = '0;
                acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                opnd_d = is_div ? b_mag : a_mag;
                if (div_zero) begin
                    state_d = S_DONE;
                    r_d     = op_q[1] ? a_q : '1;
                end else if (div_ovf) begin
                    state_d = S_DONE;
                    r_d     = op_q[1] ? '0 : a_q;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                r_d     = res_fix;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // pipeline kill aborts without touching the visible result
        if (bus.flush && ((state == S_PREP) || (state == S_CALC) || (state == S_FIX))) begin
            state_d = S_IDLE;
            r_d     = r_q;
        end
        busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            r_q    <= r_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against an arithmetic reference.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          edges = 0;
    logic [31:0] last_exp = '0;
    logic [31:0] corners [5];

    muldiv_seq_if bus();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: RV32M results from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        logic [31:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        res = '0;
        case (op)
            3'b000: begin p = sa * sb; res = p[31:0]; end
            3'b001: begin p = sa * sb; res = p[63:32]; end
            3'b010: begin p = sa * ub; res = p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; res = p[63:32]; end
            3'b100: begin
                if (b == 32'h0) res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
                else begin q = sa / sb; res = q[31:0]; end
            end
            3'b101: res = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'h0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h0;
                else begin q = sa % sb; res = q[31:0]; end
            end
            default: res = (b == 32'h0) ? a : a % b;
        endcase
        return res;
    endfunction

    // Cycle (counting PREP as cycle 1) in which done is expected
    function automatic int exp_cycles(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 35;
        if (op[2] && b == 32'h0) n = 2;
        if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) n = 2;
        return n;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(3) == 0) v = corners[$urandom_range(4)];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        edges++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operand inputs
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        cyc       = 1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input logic [31:0] exp_r, input int exp_cyc, input string tag);
        bit busy_ok;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
        end
        chk({tag, "_done_seen"}, 64'(bus.done), 64'(1));
        chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_r"}, 64'(bus.r), 64'(exp_r));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
        chk({tag, "_busy_during"}, 64'(busy_ok), 64'(1));
        last_exp = exp_r;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input string tag);
        launch(op, a, b);
        wait_done(exp_r, exp_cycles(op, a, b), tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          saw_done;
        int          done_a_edge;

        corners   = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_r", 64'(bus.r), 64'(0));
        rst_n = 1'b1;
        tick();

        // Directed vectors with hand-derived results
        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        tick();
        chk("mul_done_pulse", 64'(bus.done), 64'(0));
        chk("mul_r_held", 64'(bus.r), 64'(32'hFFFF_FFEB));
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        run_op(3'b101, 32'd100,       32'd7,         32'h0000_000E, "divu_100_7");
        run_op(3'b111, 32'd100,       32'd7,         32'h0000_0002, "remu_100_7");
        run_op(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_by_zero");
        run_op(3'b111, 32'd5,         32'd0,         32'd5,         "remu_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");

        // Random operations against the reference
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(7));
            ra  = pick();
            rb  = pick();
            run_op(rop, ra, rb, model(rop, ra, rb), "rand");
            tick();
            chk("rand_done_pulse", 64'(bus.done), 64'(0));
            chk("rand_r_held", 64'(bus.r), 64'(last_exp));
        end

        // A start while busy is dropped
        launch(3'b101, 32'd100, 32'd7);
        while (cyc < 5) tick();
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = $urandom;
        bus.b     = $urandom;
        tick();
        bus.start = 1'b0;
        wait_done(32'h0000_000E, 35, "ignored_start");
        tick();

        // Flush mid-calculation
        launch(3'b101, 32'd1000, 32'd3);
        while (cyc < 10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'(0));
        chk("flush_done", 64'(bus.done), 64'(0));
        chk("flush_r_kept", 64'(bus.r), 64'(last_exp));
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        chk("flush_no_done", 64'(saw_done), 64'(0));

        // Flush and start together in IDLE: request dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_busy", 64'(bus.busy), 64'(0));
        tick();
        tick();
        chk("flush_start_done", 64'(bus.done), 64'(0));
        run_op(3'b000, 32'd3, 32'd4, 32'h0000_000C, "mul_after_flush");
        tick();

        // Reset in the middle of a multiply
        launch(3'b000, pick(), pick());
        while (cyc < 20) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        chk("midrst_r", 64'(bus.r), 64'(0));
        last_exp = '0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("postrst_busy", 64'(bus.busy), 64'(0));

        // Back-to-back: second start issued in the first op's DONE cycle
        ra = $urandom;
        rb = $urandom;
        run_op(3'b011, ra, rb, model(3'b011, ra, rb), "b2b_mulhu");
        done_a_edge = edges;
        ra = $urandom;
        rb = $urandom | 32'h1;
        run_op(3'b101, ra, rb, model(3'b101, ra, rb), "b2b_divu");
        chk("b2b_spacing", 64'(edges - done_a_edge), 64'(35));
        tick();
        chk("final_done_pulse", 64'(bus.done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
